// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit positions, word types and
// the parity/correction helpers used by both the encoder and the decoder.
package hamming_pkg;

  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  typedef logic [6:0] code7_t;
  typedef logic [3:0] data4_t;
  typedef logic [2:0] synd3_t;

  // Check bits {p4,p2,p1} for data {d3,d2,d1,d0}.
  function automatic synd3_t hamming_parity(input data4_t d);
    synd3_t p;
    p[0] = d[0] ^ d[1] ^ d[3];
    p[1] = d[0] ^ d[2] ^ d[3];
    p[2] = d[1] ^ d[2] ^ d[3];
    return p;
  endfunction

  function automatic data4_t code_data(input code7_t c);
    return {c[D3], c[D2], c[D1], c[D0]};
  endfunction

  function automatic synd3_t code_parity(input code7_t c);
    return {c[P4], c[P2], c[P1]};
  endfunction

  // A nonzero syndrome is the 1-based position of the bit to invert.
  function automatic code7_t syndrome_to_mask(input synd3_t s);
    code7_t m;
    case (s)
      3'd1:    m = 7'b0000001;
      3'd2:    m = 7'b0000010;
      3'd3:    m = 7'b0000100;
      3'd4:    m = 7'b0001000;
      3'd5:    m = 7'b0010000;
      3'd6:    m = 7'b0100000;
      3'd7:    m = 7'b1000000;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hamming_syndrome_7_4.sv
// Combinational Hamming(7,4) syndrome {s4,s2,s1}: received check bits
// compared against check bits recomputed from the received data bits.
module hamming_syndrome_7_4
  import hamming_pkg::*;
(
  input  logic [6:0] code_in,
  output logic [2:0] syndrome_out
);

  synd3_t w_recomputed;

  assign w_recomputed = hamming_parity(code_data(code_in));
  assign syndrome_out = code_parity(code_in) ^ w_recomputed;

endmodule

// File: rtl/hamming_decoder_7_4.sv
// Two-stage pipelined Hamming(7,4) single-error-correcting decoder with
// valid/ready streams. Define HAMMING_DEC_STATS_EN for the corrected-word counter.
module hamming_decoder_7_4
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       code_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       data_out,
  output logic [2:0]       syndrome_out,
  output logic             err_corrected,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] err_count
);

  logic   w_adv;
  synd3_t w_synd;
  code7_t w_corr_code;

  logic   r_s1_valid;
  code7_t r_s1_code;
  synd3_t r_s1_synd;

  logic   r_out_valid;
  data4_t r_data;
  synd3_t r_synd;
  logic   r_err;

  // The whole pipeline moves as one unit; it only holds when the output is blocked.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  hamming_syndrome_7_4 u_syndrome (
    .code_in      (code_in),
    .syndrome_out (w_synd)
  );

  // Stage 1: capture the raw codeword and its syndrome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= 7'b0000000;
      r_s1_synd  <= 3'b000;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_code  <= code_in;
      r_s1_synd  <= w_synd;
    end
  end

  assign w_corr_code = r_s1_code ^ syndrome_to_mask(r_s1_synd);

  // Stage 2: corrected data and status, driven straight to the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_data      <= 4'b0000;
      r_synd      <= 3'b000;
      r_err       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      r_data      <= code_data(w_corr_code);
      r_synd      <= r_s1_synd;
      r_err       <= (r_s1_synd != 3'b000);
    end
  end

  assign out_valid     = r_out_valid;
  assign data_out      = r_data;
  assign syndrome_out  = r_synd;
  assign err_corrected = r_err;

`ifdef HAMMING_DEC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_cnt_inc;
  logic [CNT_W-1:0] r_err_count;

  assign w_cnt_inc = r_out_valid && out_ready && r_err;

  // Saturating corrected-word counter; clear takes priority over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (cnt_clear) begin
      r_err_count <= '0;
    end else if (w_cnt_inc && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_cnt_clear;

  assign w_unused_cnt_clear = cnt_clear;
  assign err_count          = '0;
`endif

endmodule
